// File: rtl/btb_update_queue_pkg.sv
// Shared types and constants for the BTB update queue.
// Address width is fixed here because the entry struct depends on it.
package btb_pkg;

  localparam int AMSB   = 31;
  localparam int NLANES = 3;

  // One queued BTB write: branch pc, resolved target, resolved direction.
  typedef struct packed {
    logic [AMSB:0] pc;
    logic [AMSB:0] tgt;
    logic          taken;
  } btb_upd_t;

  // Two branches collide in the BTB when they match above bit 0.
  function automatic logic same_line(input logic [AMSB:0] a, input logic [AMSB:0] b);
    return a[AMSB:1] == b[AMSB:1];
  endfunction

endpackage

// File: rtl/btb_update_queue_if.sv
// Bus bundles for the BTB update queue.
//
// Handshakes:
// - Lane side: a lane is taken on a clock edge when br_v && br_upd && in_rdy.
//   The whole three-lane group is accepted together. While in_rdy=0 the lane
//   inputs are ignored, and the branch units hold them.
// - Write side: out_wr is a valid signal and out_rdy is the matching ready.
//   An entry is consumed on an edge where out_wr && out_rdy. While out_wr && !out_rdy,
//   out_wadr, out_wdat and out_valid stay stable.
interface btb_br_if;
  import btb_pkg::*;
  logic [NLANES-1:0]         br_v;
  logic [NLANES-1:0]         br_upd;
  logic [NLANES-1:0]         br_taken;
  logic [NLANES-1:0][AMSB:0] br_pc;
  logic [NLANES-1:0][AMSB:0] br_tgt;
  logic                      in_rdy;

  modport master (output br_v, br_upd, br_taken, br_pc, br_tgt, input in_rdy);
  modport slave  (input br_v, br_upd, br_taken, br_pc, br_tgt, output in_rdy);
endinterface

interface btb_wr_if;
  import btb_pkg::*;
  logic          out_wr;
  logic [AMSB:0] out_wadr;
  logic [AMSB:0] out_wdat;
  logic          out_valid;
  logic          out_rdy;

  modport master (output out_wr, out_wadr, out_wdat, out_valid, input out_rdy);
  modport slave  (input out_wr, out_wadr, out_wdat, out_valid, output out_rdy);
endinterface

// File: rtl/btb_update_queue_compact.sv
// Combinational front end: qualifies the lanes, drops same-cycle duplicates
// (the youngest lane wins), and packs the survivors into slot0..slot2 in lane order.
module btb_upd_compact
  import btb_pkg::*;
(
  input  logic                      i_in_rdy,
  input  logic [NLANES-1:0]         i_br_v,
  input  logic [NLANES-1:0]         i_br_upd,
  input  logic [NLANES-1:0]         i_br_taken,
  input  logic [NLANES-1:0][AMSB:0] i_br_pc,
  input  logic [NLANES-1:0][AMSB:0] i_br_tgt,
  output logic [1:0]                o_k,
  output btb_upd_t                  o_slot0,
  output btb_upd_t                  o_slot1,
  output btb_upd_t                  o_slot2
);

  logic [NLANES-1:0] w_cand;
  logic [NLANES-1:0] w_surv;
  logic [1:0]        w_idx;
  btb_upd_t          w_slot [NLANES];

  // A lane is a candidate only when it needs a write and the queue has room.
  always_comb begin
    w_cand = i_br_v & i_br_upd & {NLANES{i_in_rdy}};
  end

  // Drop an older lane when a younger candidate hits the same BTB line.
  always_comb begin
    w_surv = w_cand;
    for (int n = 0; n < NLANES; n++) begin
      for (int m = n + 1; m < NLANES; m++) begin
        if (w_cand[m] && same_line(i_br_pc[m], i_br_pc[n])) begin
          w_surv[n] = 1'b0;
        end
      end
    end
  end

  // Pack survivors into consecutive slots with no holes.
  always_comb begin
    w_idx = 2'd0;
    for (int s = 0; s < NLANES; s++) begin
      w_slot[s] = '0;
    end
    for (int n = 0; n < NLANES; n++) begin
      if (w_surv[n]) begin
        w_slot[w_idx].pc    = i_br_pc[n];
        w_slot[w_idx].tgt   = i_br_tgt[n];
        w_slot[w_idx].taken = i_br_taken[n];
        w_idx = w_idx + 2'd1;
      end
    end
    o_k = w_idx;
  end

  assign o_slot0 = w_slot[0];
  assign o_slot1 = w_slot[1];
  assign o_slot2 = w_slot[2];

endmodule

// File: rtl/btb_update_queue.sv
// BTB update queue: accepts up to three filtered updates per cycle, buffers
// them in order, and drains one per cycle through a registered write port.
module btb_update_queue
  import btb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk4x,
  input  logic                   rst,
  btb_br_if.slave                br,
  btb_wr_if.master               wr,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            upd_cnt
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  btb_upd_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW-1:0]   r_count;
  logic [15:0]     r_upd_cnt;
  btb_upd_t        r_out;
  logic            r_out_wr;

  logic            w_in_rdy;
  logic [1:0]      w_k;
  btb_upd_t        w_slot0;
  btb_upd_t        w_slot1;
  btb_upd_t        w_slot2;
  logic [IW-1:0]   w_widx0;
  logic [IW-1:0]   w_widx1;
  logic [IW-1:0]   w_widx2;
  logic            w_empty;
  logic            w_deq;
  btb_upd_t        w_head;
  logic [16:0]     w_upd_sum;

  // Room for a full three-lane group, decided from registered occupancy only.
  assign w_in_rdy  = (PW'(DEPTH) - r_count) >= PW'(3);
  assign br.in_rdy = w_in_rdy;

  btb_upd_compact u_compact (
    .i_in_rdy   (w_in_rdy),
    .i_br_v     (br.br_v),
    .i_br_upd   (br.br_upd),
    .i_br_taken (br.br_taken),
    .i_br_pc    (br.br_pc),
    .i_br_tgt   (br.br_tgt),
    .o_k        (w_k),
    .o_slot0    (w_slot0),
    .o_slot1    (w_slot1),
    .o_slot2    (w_slot2)
  );

  assign w_widx0   = r_wptr[IW-1:0];
  assign w_widx1   = r_wptr[IW-1:0] + IW'(1);
  assign w_widx2   = r_wptr[IW-1:0] + IW'(2);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_head    = r_mem[r_rptr[IW-1:0]];
  // The output register takes the head whenever it is free or being consumed.
  assign w_deq     = !w_empty && (!r_out_wr || wr.out_rdy);
  assign w_upd_sum = {1'b0, r_upd_cnt} + 17'(w_k);

  // Storage: write the packed survivors at wptr, wptr+1, wptr+2.
  always_ff @(posedge clk4x) begin
    if (!rst) begin
      if (w_k >= 2'd1) r_mem[w_widx0] <= w_slot0;
      if (w_k >= 2'd2) r_mem[w_widx1] <= w_slot1;
      if (w_k >= 2'd3) r_mem[w_widx2] <= w_slot2;
    end
  end

  // Pointers, occupancy and the saturating update counter.
  always_ff @(posedge clk4x) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_upd_cnt <= '0;
    end else begin
      r_wptr    <= r_wptr + PW'(w_k);
      r_rptr    <= r_rptr + PW'(w_deq);
      r_count   <= r_count + PW'(w_k) - PW'(w_deq);
      r_upd_cnt <= w_upd_sum[16] ? 16'hFFFF : w_upd_sum[15:0];
    end
  end

  // Output stage: load the head, drop the request once consumed, else hold.
  always_ff @(posedge clk4x) begin
    if (rst) begin
      r_out_wr <= 1'b0;
      r_out    <= '0;
    end else if (w_deq) begin
      r_out_wr <= 1'b1;
      r_out    <= w_head;
    end else if (r_out_wr && wr.out_rdy) begin
      r_out_wr <= 1'b0;
    end
  end

  assign wr.out_wr    = r_out_wr;
  assign wr.out_wadr  = r_out.pc;
  assign wr.out_wdat  = r_out.tgt;
  assign wr.out_valid = r_out.taken;
  assign count        = r_count;
  assign upd_cnt      = r_upd_cnt;

endmodule

// File: tb/tb_btb_update_queue.sv
// Bench for btb_update_queue: a queue-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_btb_update_queue;
  import btb_pkg::*;

  localparam int DEPTH = 16;

  logic        clk4x;
  logic        rst;
  logic [4:0]  count;
  logic [15:0] upd_cnt;

  btb_br_if br ();
  btb_wr_if wr ();

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .clk4x   (clk4x),
    .rst     (rst),
    .br      (br),
    .wr      (wr),
    .count   (count),
    .upd_cnt (upd_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk4x = 1'b0;
  always #5 clk4x = ~clk4x;

  int vectors;
  int errors;
  bit cmp_en;
  bit toggle_en;
  int cyc;

  // ---------------- reference model ----------------
  btb_upd_t    m_fifo[$];
  btb_upd_t    m_new[$];
  btb_upd_t    m_out;
  bit          m_out_v;
  int          m_upd;
  bit          m_acc;
  logic [31:0] log_pc[$];
  int          log_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk4x) begin
    int          tot;
    bit          keep;
    logic [31:0] pa;
    logic [31:0] pb;
    cyc++;
    if (wr.out_wr === 1'b1 && wr.out_rdy === 1'b1) begin
      log_pc.push_back(wr.out_wadr);
      log_cyc.push_back(cyc);
    end
    if (rst) begin
      m_fifo.delete();
      m_out_v = 1'b0;
      m_out   = '0;
      m_upd   = 0;
      m_acc   = 1'b0;
    end else begin
      m_acc = (DEPTH - m_fifo.size()) >= 3;
      m_new.delete();
      for (int n = 0; n < 3; n++) begin
        if (m_acc && br.br_v[n] && br.br_upd[n]) begin
          keep = 1'b1;
          pa   = br.br_pc[n];
          for (int m = n + 1; m < 3; m++) begin
            pb = br.br_pc[m];
            if (br.br_v[m] && br.br_upd[m] && pa[31:1] == pb[31:1]) keep = 1'b0;
          end
          if (keep) m_new.push_back('{pc: br.br_pc[n], tgt: br.br_tgt[n], taken: br.br_taken[n]});
        end
      end
      if (m_fifo.size() > 0 && (!m_out_v || wr.out_rdy)) begin
        m_out   = m_fifo.pop_front();
        m_out_v = 1'b1;
      end else if (m_out_v && wr.out_rdy) begin
        m_out_v = 1'b0;
      end
      foreach (m_new[i]) m_fifo.push_back(m_new[i]);
      tot   = m_upd + m_new.size();
      m_upd = (tot > 65535) ? 65535 : tot;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk4x) begin
    if (cmp_en) begin
      chk("out_wr", 64'(wr.out_wr), 64'(m_out_v));
      if (m_out_v) begin
        chk("out_wadr", 64'(wr.out_wadr), 64'(m_out.pc));
        chk("out_wdat", 64'(wr.out_wdat), 64'(m_out.tgt));
        chk("out_valid", 64'(wr.out_valid), 64'(m_out.taken));
      end
      chk("count", 64'(count), 64'(m_fifo.size()));
      chk("in_rdy", 64'(br.in_rdy), 64'((DEPTH - m_fifo.size()) >= 3));
      chk("upd_cnt", 64'(upd_cnt), 64'(m_upd));
    end
  end

  always @(negedge clk4x) begin
    if (toggle_en) wr.out_rdy = ~wr.out_rdy;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_lanes();
    br.br_v     = '0;
    br.br_upd   = '0;
    br.br_taken = '0;
    br.br_pc    = '0;
    br.br_tgt   = '0;
  endtask

  task automatic set_lane(input int n, input bit v, input bit upd,
                          input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    br.br_v[n]     = v;
    br.br_upd[n]   = upd;
    br.br_pc[n]    = pc;
    br.br_tgt[n]   = tgt;
    br.br_taken[n] = tk;
  endtask

  task automatic do_reset();
    @(negedge clk4x);
    rst       = 1'b1;
    toggle_en = 1'b0;
    wr.out_rdy = 1'b0;
    clear_lanes();
    @(negedge clk4x);
    rst    = 1'b0;
    cmp_en = 1'b1;
  endtask

  // Wait (bounded) for the edge at which the current lane group is accepted.
  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(posedge clk4x);
      #1;
      if (m_acc) ok = 1'b1;
    end
    chk(name, 64'(ok), 64'(1));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int lb;
    logic [31:0] exp_pc;
    vectors = 0; errors = 0; cmp_en = 1'b0; toggle_en = 1'b0; cyc = 0;
    rst = 1'b1;
    wr.out_rdy = 1'b0;
    clear_lanes();
    repeat (2) @(negedge clk4x);

    // Reset values
    do_reset();
    chk("rst_out_wr", 64'(wr.out_wr), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_rdy", 64'(br.in_rdy), 64'(1));
    chk("rst_upd_cnt", 64'(upd_cnt), 64'(0));
    chk("rst_wadr", 64'(wr.out_wadr), 64'(0));

    // Single lane: one-cycle latency to out_wr, consumed the next cycle
    wr.out_rdy = 1'b1;
    set_lane(0, 1, 1, 32'h1000, 32'h2000, 1);
    wait_accept("single_acc");
    @(negedge clk4x);
    clear_lanes();
    @(negedge clk4x);
    chk("single_wr", 64'(wr.out_wr), 64'(1));
    chk("single_wadr", 64'(wr.out_wadr), 64'(32'h1000));
    chk("single_wdat", 64'(wr.out_wdat), 64'(32'h2000));
    chk("single_valid", 64'(wr.out_valid), 64'(1));
    @(negedge clk4x);
    chk("single_drop", 64'(wr.out_wr), 64'(0));

    // Filter and dedup: lane1 needs no write, lane2 supersedes lane0
    do_reset();
    wr.out_rdy = 1'b1;
    set_lane(0, 1, 1, 32'h40, 32'hA0, 1);
    set_lane(1, 1, 0, 32'h80, 32'hB0, 1);
    set_lane(2, 1, 1, 32'h40, 32'hC0, 0);
    wait_accept("dedup_acc");
    @(negedge clk4x);
    clear_lanes();
    chk("dedup_count", 64'(count), 64'(1));
    chk("dedup_upd_cnt", 64'(upd_cnt), 64'(1));
    @(negedge clk4x);
    chk("dedup_wr", 64'(wr.out_wr), 64'(1));
    chk("dedup_wdat", 64'(wr.out_wdat), 64'(32'hC0));
    chk("dedup_valid", 64'(wr.out_valid), 64'(0));
    @(negedge clk4x);
    chk("dedup_single", 64'(wr.out_wr), 64'(0));

    // Ordering: two full groups drain back to back
    do_reset();
    wr.out_rdy = 1'b1;
    lb = log_pc.size();
    for (int n = 0; n < 3; n++) set_lane(n, 1, 1, 32'h10 * (n + 1), 32'h1000 + n, 1);
    wait_accept("ord_acc0");
    @(negedge clk4x);
    wait_accept("ord_acc1");
    @(negedge clk4x);
    clear_lanes();
    repeat (10) @(negedge clk4x);
    chk("ord_total", 64'(log_pc.size() - lb), 64'(6));
    for (int i = 0; i < 6 && lb + i < log_pc.size(); i++) begin
      exp_pc = 32'h10 * ((i % 3) + 1);
      chk("ord_pc", 64'(log_pc[lb + i]), 64'(exp_pc));
      if (i > 0) chk("ord_gap", 64'(log_cyc[lb + i] - log_cyc[lb + i - 1]), 64'(1));
    end

    // Backpressure: fill with out_rdy=0, then drain everything in order
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int n = 0; n < 3; n++) set_lane(n, 1, 1, 32'h1000 + 32'h100 * g + 32'h10 * n, 32'h5000 + g * 3 + n, n[0]);
      wait_accept("bp_acc");
      @(negedge clk4x);
    end
    clear_lanes();
    chk("bp_count", 64'(count), 64'(14));
    chk("bp_in_rdy", 64'(br.in_rdy), 64'(0));
    for (int h = 0; h < 3; h++) begin
      chk("bp_hold_wr", 64'(wr.out_wr), 64'(1));
      chk("bp_hold_wadr", 64'(wr.out_wadr), 64'(32'h1000));
      chk("bp_hold_wdat", 64'(wr.out_wdat), 64'(32'h5000));
      @(negedge clk4x);
    end
    lb = log_pc.size();
    wr.out_rdy = 1'b1;
    repeat (20) @(negedge clk4x);
    chk("bp_drained", 64'(log_pc.size() - lb), 64'(15));
    for (int i = 0; i < 15 && lb + i < log_pc.size(); i++) begin
      exp_pc = 32'h1000 + 32'h100 * (i / 3) + 32'h10 * (i % 3);
      chk("bp_order", 64'(log_pc[lb + i]), 64'(exp_pc));
    end
    chk("bp_empty", 64'(count), 64'(0));

    // Wrap-around: 40 single-lane updates with out_rdy toggling
    do_reset();
    lb = log_pc.size();
    toggle_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_lane(0, 1, 1, 32'h2000 + 32'h4 * i, 32'(i), i[0]);
      wait_accept("wrap_acc");
      @(negedge clk4x);
    end
    clear_lanes();
    toggle_en = 1'b0;
    wr.out_rdy = 1'b1;
    repeat (40) @(negedge clk4x);
    chk("wrap_total", 64'(log_pc.size() - lb), 64'(40));
    for (int i = 0; i < 40 && lb + i < log_pc.size(); i++) begin
      exp_pc = 32'h2000 + 32'h4 * i;
      chk("wrap_order", 64'(log_pc[lb + i]), 64'(exp_pc));
    end
    chk("wrap_count", 64'(count), 64'(0));
    chk("wrap_upd_cnt", 64'(upd_cnt), 64'(40));

    // Mid-operation reset with 8 queued entries and a pending write
    do_reset();
    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < 3; n++) set_lane(n, 1, 1, 32'h3000 + 32'h100 * g + 32'h10 * n, 32'h7000, 1);
      wait_accept("mr_acc");
      @(negedge clk4x);
    end
    clear_lanes();
    chk("mr_pre_count", 64'(count), 64'(8));
    chk("mr_pre_wr", 64'(wr.out_wr), 64'(1));
    rst = 1'b1;
    @(negedge clk4x);
    rst = 1'b0;
    chk("mr_wr", 64'(wr.out_wr), 64'(0));
    chk("mr_count", 64'(count), 64'(0));
    chk("mr_in_rdy", 64'(br.in_rdy), 64'(1));
    chk("mr_upd_cnt", 64'(upd_cnt), 64'(0));
    repeat (3) @(negedge clk4x);
    chk("mr_nodrain", 64'(wr.out_wr), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
